// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_entry_t  : {pc, instr} pair buffered in the prefetch FIFO
//   FETCH_STATE_e  : fetch control state (RUN issuing, HOLD waiting for space)
//   WORD_BYTES     : byte stride between consecutive fetches
//   BE_WORD        : byte-enable pattern for a full-word read
//   next_pc()      : sequential PC increment (wraps modulo 2^32)
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int         WORD_BYTES = 4;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } FETCH_STATE_e;

   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'(WORD_BYTES);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Prefetch buffer between the code-memory response and decode. Head entry is
// read straight from storage, so a pushed word becomes visible the cycle after
// the push. Flush empties the buffer and takes priority over push and pop.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write one entry (never issued while full)
//   i_pop          : consume the head entry (ignored when empty)
//   i_flush        : discard all entries
//   o_valid        : buffer non-empty
//   o_head         : head entry
//   o_count        : number of stored entries
// -----------------------------------------------------------------------------
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  fetch_entry_t     i_data,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic             o_valid,
   output fetch_entry_t     o_head,
   output logic [CNT_W-1:0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_pop;

   assign w_do_pop = i_pop && (r_count != '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (i_push && !w_do_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!i_push && w_do_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // The issue rule upstream guarantees a free slot for every returning word.
   a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(i_push && !i_flush && !w_do_pop && (r_count == CNT_W'(DEPTH))));

   assign o_valid = (r_count != '0);
   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: owns the PC, issues word reads to code memory (1-cycle read
// latency) and hands {PC, instruction} pairs to decode through a prefetch FIFO.
// Redirects flush the FIFO, drop the response returning that cycle and reload
// the PC.
// Optional feature macro: FETCH_ALIGN_CHECK_EN -- a misaligned PC raises a
// sticky oFault and stalls fetch until the next redirect. Without it the low
// two bits of a redirect target are cleared and oFault is tied low.
// Ports:
//   iCLK, iRST_N               : clock, asynchronous active-low reset
//   oReadEnable/oAddress       : code-memory read request
//   oWriteEnable/oByteEnable   : constant word-read qualifiers
//   iReadData                  : read data, one cycle after oReadEnable
//   iRedirect/iRedirectPC      : redirect request and target
//   oValid/iReady              : decode handshake
//   oInstr/oInstrPC            : head instruction and its PC
//   oFault                     : misaligned-fetch fault
// -----------------------------------------------------------------------------
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   output logic        oReadEnable,
   output logic        oWriteEnable,
   output logic [3:0]  oByteEnable,
   output logic [31:0] oAddress,
   input  logic [31:0] iReadData,
   input  logic        iRedirect,
   input  logic [31:0] iRedirectPC,
   output logic        oValid,
   input  logic        iReady,
   output logic [31:0] oInstr,
   output logic [31:0] oInstrPC,
   output logic        oFault
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W = CNT_W + 1;

   logic [31:0]  r_pc;
   logic [31:0]  r_req_pc;
   logic         r_inflight;
   logic         r_kill;
   FETCH_STATE_e r_state;
   FETCH_STATE_e w_state_nxt;

   logic             w_head_vld;
   fetch_entry_t     w_head;
   fetch_entry_t     w_push_data;
   logic [CNT_W-1:0] w_count;
   logic [OCC_W-1:0] w_occ;
   logic             w_pop;
   logic             w_push;
   logic             w_rule_ok;
   logic             w_issue;
   logic             w_misaligned;
   logic             w_fault;
   logic [31:0]      w_redirect_pc;

`ifdef FETCH_ALIGN_CHECK_EN
   logic r_fault;

   assign w_misaligned  = (r_pc[1:0] != 2'b00);
   assign w_redirect_pc = iRedirectPC;
   assign w_fault       = r_fault;

   // Fault latches when a misaligned PC reaches issue and holds until redirect.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_fault <= 1'b0;
      end else if (iRedirect) begin
         r_fault <= 1'b0;
      end else if (w_misaligned) begin
         r_fault <= 1'b1;
      end
   end
`else
   assign w_misaligned  = 1'b0;
   assign w_redirect_pc = iRedirectPC & 32'hFFFF_FFFC;
   assign w_fault       = 1'b0;
`endif

   assign oValid = w_head_vld && !w_fault;
   assign w_pop  = oValid && iReady;

   // Slots already committed (stored + returning) minus the one leaving now.
   assign w_occ     = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
   assign w_rule_ok = (w_occ < OCC_W'(FIFO_DEPTH));
   assign w_issue   = w_rule_ok && !iRedirect && !w_fault && !w_misaligned;

   // A redirect in the response cycle, or the slot right after one, kills the word.
   assign w_push      = r_inflight && !r_kill && !iRedirect;
   assign w_push_data = '{pc: r_req_pc, instr: iReadData};

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .i_clk   (iCLK),
      .i_rst_n (iRST_N),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .i_flush (iRedirect),
      .o_valid (w_head_vld),
      .o_head  (w_head),
      .o_count (w_count)
   );

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_pc       <= RESET_PC;
         r_req_pc   <= '0;
         r_inflight <= 1'b0;
         r_kill     <= 1'b0;
         r_state    <= RUN;
      end else begin
         r_inflight <= w_issue;
         r_kill     <= iRedirect;
         r_state    <= w_state_nxt;
         if (iRedirect) begin
            r_pc <= w_redirect_pc;
         end else if (w_issue) begin
            r_req_pc <= r_pc;
            r_pc     <= next_pc(r_pc);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:     if (!w_rule_ok && !iRedirect) w_state_nxt = HOLD;
         HOLD:    if (w_pop || iRedirect)       w_state_nxt = RUN;
         default: w_state_nxt = RUN;
      endcase
   end

   // Reset gating keeps the strobe low while the block is held in reset.
   assign oReadEnable  = w_issue && iRST_N;
   assign oAddress     = r_pc;
   assign oWriteEnable = 1'b0;
   assign oByteEnable  = BE_WORD;
   assign oInstr       = w_head.instr;
   assign oInstrPC     = w_head.pc;
   assign oFault       = w_fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   localparam int          DEPTH = 2;
   localparam logic [31:0] KEY   = 32'hA5A5_0000;

   logic        iCLK = 1'b0;
   logic        iRST_N;
   logic        oReadEnable;
   logic        oWriteEnable;
   logic [3:0]  oByteEnable;
   logic [31:0] oAddress;
   logic [31:0] iReadData;
   logic        iRedirect;
   logic [31:0] iRedirectPC;
   logic        oValid;
   logic        iReady;
   logic [31:0] oInstr;
   logic [31:0] oInstrPC;
   logic        oFault;

   instr_fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .iCLK         (iCLK),
      .iRST_N       (iRST_N),
      .oReadEnable  (oReadEnable),
      .oWriteEnable (oWriteEnable),
      .oByteEnable  (oByteEnable),
      .oAddress     (oAddress),
      .iReadData    (iReadData),
      .iRedirect    (iRedirect),
      .iRedirectPC  (iRedirectPC),
      .oValid       (oValid),
      .iReady       (iReady),
      .oInstr       (oInstr),
      .oInstrPC     (oInstrPC),
      .oFault       (oFault)
   );

   always #5 iCLK = ~iCLK;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: next PC decode must see, next address memory must see.
   logic [31:0] exp_pc;
   logic [31:0] exp_fa;
   int          n_reads;
   int          n_acc;

   // Per-cycle samples taken at the falling edge.
   logic        s_valid, s_re, s_fault;
   logic [31:0] s_pc, s_addr;

   logic        pend_re;
   logic [31:0] pend_addr;
   logic [31:0] ra [8];
   int          nra;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] redir_target(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
      return t;
`else
      return t & 32'hFFFF_FFFC;
`endif
   endfunction

   task automatic reset_model();
      exp_pc = 32'h0;
      exp_fa = 32'h0;
   endtask

   // One clock cycle: sample and score at negedge, answer memory after posedge.
   task automatic tick();
      @(negedge iCLK);
      s_valid = oValid;
      s_pc    = oInstrPC;
      s_re    = oReadEnable;
      s_addr  = oAddress;
      s_fault = oFault;
      check("occupancy_bound", 32'((exp_fa - exp_pc) <= 32'(4 * DEPTH)), 32'd1);
      if (iRedirect) begin
         check("no_read_on_redirect", 32'(s_re), 32'd0);
         exp_pc = redir_target(iRedirectPC);
         exp_fa = exp_pc;
      end else begin
         if (s_valid && iReady) begin
            check("deliver_pc", oInstrPC, exp_pc);
            check("deliver_instr", oInstr, exp_pc ^ KEY);
            exp_pc = exp_pc + 32'd4;
            n_acc++;
         end
         if (s_re) begin
            check("read_addr", s_addr, exp_fa);
            exp_fa = exp_fa + 32'd4;
            n_reads++;
         end
      end
      pend_re   = s_re;
      pend_addr = s_addr;
      @(posedge iCLK);
      #1;
      iReadData = pend_re ? (pend_addr ^ KEY) : $urandom();
   endtask

   task automatic redirect(input logic [31:0] t);
      iRedirect   = 1'b1;
      iRedirectPC = t;
      tick();
      iRedirect   = 1'b0;
   endtask

   initial begin
      iRST_N      = 1'b0;
      iReady      = 1'b0;
      iRedirect   = 1'b0;
      iRedirectPC = 32'h0;
      iReadData   = 32'h0;
      n_reads     = 0;
      n_acc       = 0;
      reset_model();

      // Reset state
      #3;
      check("rst_valid", 32'(oValid), 32'd0);
      check("rst_re", 32'(oReadEnable), 32'd0);
      check("rst_addr", oAddress, 32'h0);
      check("rst_instr", oInstr, 32'h0);
      check("rst_instr_pc", oInstrPC, 32'h0);
      check("rst_fault", 32'(oFault), 32'd0);
      check("rst_we", 32'(oWriteEnable), 32'd0);
      check("rst_be", 32'(oByteEnable), 32'hF);

      // Streaming from reset: first delivery on cycle 2, then one per cycle
      @(posedge iCLK);
      #1;
      iRST_N = 1'b1;
      iReady = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         check("stream_valid", 32'(s_valid), 32'(c >= 2));
         check("stream_re", 32'(s_re), 32'd1);
         if (c >= 2) check("stream_pc", s_pc, 32'(4 * (c - 2)));
      end

      // Asynchronous reset mid-burst clears outputs immediately
      iRST_N = 1'b0;
      #1;
      check("midrst_valid", 32'(oValid), 32'd0);
      check("midrst_re", 32'(oReadEnable), 32'd0);
      check("midrst_instr", oInstr, 32'h0);
      check("midrst_instr_pc", oInstrPC, 32'h0);
      check("midrst_addr", oAddress, 32'h0);
      reset_model();

      // Decode stalled: exactly DEPTH reads, head held at PC 0
      iReady = 1'b0;
      @(posedge iCLK);
      #1;
      iRST_N  = 1'b1;
      n_reads = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (c >= 2) begin
            check("stall_valid", 32'(s_valid), 32'd1);
            check("stall_head_pc", s_pc, 32'h0);
         end
      end
      check("stall_reads", 32'(n_reads), 32'(DEPTH));
      check("stall_re_off", 32'(s_re), 32'd0);

      // Redirect with a read in flight
      iReady = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      check("pre_redir_re", 32'(s_re), 32'd1);
      redirect(32'h0040_0000);
      tick();
      check("redir_valid_c1", 32'(s_valid), 32'd0);
      check("redir_addr_c1", s_addr, 32'h0040_0000);
      check("redir_re_c1", 32'(s_re), 32'd1);
      tick();
      check("redir_valid_c2", 32'(s_valid), 32'd0);
      tick();
      check("redir_valid_c3", 32'(s_valid), 32'd1);
      check("redir_pc_c3", s_pc, 32'h0040_0000);

      // Redirect coinciding with pop and push
      for (int c = 0; c < 3; c++) tick();
      iRedirect   = 1'b1;
      iRedirectPC = 32'h0000_1000;
      tick();
      iRedirect = 1'b0;
      check("rpp_pre_valid", 32'(s_valid), 32'd1);
      tick();
      check("rpp_flushed", 32'(s_valid), 32'd0);
      tick();
      tick();
      for (int c = 0; c < 3; c++) begin
         check("rpp_seq_valid", 32'(s_valid), 32'd1);
         check("rpp_seq_pc", s_pc, 32'h0000_1000 + 32'(4 * c));
         tick();
      end

      // PC wrap at the top of the address space
      redirect(32'hFFFF_FFF8);
      nra = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (s_re && nra < 8) begin
            ra[nra] = s_addr;
            nra++;
         end
      end
      check("wrap_a0", ra[0], 32'hFFFF_FFF8);
      check("wrap_a1", ra[1], 32'hFFFF_FFFC);
      check("wrap_a2", ra[2], 32'h0000_0000);

      // Misaligned redirect target
      redirect(32'h0040_0002);
`ifdef FETCH_ALIGN_CHECK_EN
      n_reads = 0;
      for (int c = 0; c < 5; c++) tick();
      check("fault_reads", 32'(n_reads), 32'd0);
      check("fault_set", 32'(s_fault), 32'd1);
      check("fault_valid", 32'(s_valid), 32'd0);
      redirect(32'h0040_0000);
      tick();
      check("fault_clear", 32'(s_fault), 32'd0);
      check("fault_resume_addr", s_addr, 32'h0040_0000);
      tick();
      tick();
      check("fault_resume_pc", s_pc, 32'h0040_0000);
`else
      tick();
      check("align_addr", s_addr, 32'h0040_0000);
      tick();
      tick();
      check("align_valid", 32'(s_valid), 32'd1);
      check("align_pc", s_pc, 32'h0040_0000);
      check("align_fault", 32'(s_fault), 32'd0);
`endif

      // Randomized traffic against the reference model
      n_acc = 0;
      for (int c = 0; c < 400; c++) begin
         iReady      = ($urandom_range(0, 3) != 0);
         iRedirect   = ($urandom_range(0, 15) == 0);
         iRedirectPC = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
         tick();
      end
      iRedirect = 1'b0;
      check("random_progress", 32'(n_acc > 100), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
